rgu_ray_fifo: RTL

RGU_RAY_FIFO -- requirements
Module: rgu_ray_fifo

---
 rtl/rgu_ray_fifo_pkg.sv | 18 +
 rtl/rgu_fifo_mem.sv | 35 +++
 rtl/rgu_ray_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rgu_ray_fifo_pkg.sv
// rgu_ray_fifo_pkg: shared widths and limits for the ray FIFO slice.
// The GPU_WORD / RGU_FIFO_DEPTH defaults below stand in for the values that
// normally arrive from Definitions.v; an existing definition is left intact.
// Optional feature macro used by this slice: RGU_FIFO_DROP_COUNT_EN.
`ifndef GPU_WORD
`define GPU_WORD 32
`endif
`ifndef RGU_FIFO_DEPTH
`define RGU_FIFO_DEPTH 16
`endif

package rgu_ray_fifo_pkg;

  localparam int unsigned GPU_WORD_W   = `GPU_WORD;
  localparam int unsigned DROP_CNT_W   = 8;
  localparam int unsigned DROP_CNT_MAX = (1 << DROP_CNT_W) - 1;

endpackage

// File: rtl/rgu_fifo_mem.sv
// rgu_fifo_mem: DEPTH x GPU_WORD register array, one synchronous write port,
// one asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module rgu_fifo_mem
  import rgu_ray_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [GPU_WORD_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [GPU_WORD_W-1:0] rdata
);

  logic [GPU_WORD_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Show-ahead read port
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rgu_ray_fifo.sv
// rgu_ray_fifo: show-ahead FIFO between the RayGenerationUnit and its consumer.
// Optional feature macro: RGU_FIFO_DROP_COUNT_EN (saturating dropped-push counter;
// without it oDropCount is tied to zero and no counter is built).
//   iClock      : clock, rising edge
//   iReset      : synchronous active-high reset
//   iFifoPush   : write strobe
//   iFifoData   : write data
//   iFlush      : synchronous discard of all stored words
//   iReady      : consumer accepts oData this cycle
//   oValid      : oData holds the oldest stored word
//   oData       : head-of-queue word
//   oFull       : count == DEPTH
//   oAlmostFull : count >= AFULL_LEVEL
//   oCount      : number of stored words
//   oOverflow   : sticky, set when a push is dropped
//   oDropCount  : number of dropped pushes (saturating)
module rgu_ray_fifo
  import rgu_ray_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = `RGU_FIFO_DEPTH,
  parameter int unsigned AFULL_LEVEL = 12,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iFifoPush,
  input  logic [GPU_WORD_W-1:0] iFifoData,
  input  logic                  iFlush,
  input  logic                  iReady,
  output logic                  oValid,
  output logic [GPU_WORD_W-1:0] oData,
  output logic                  oFull,
  output logic                  oAlmostFull,
  output logic [AW:0]           oCount,
  output logic                  oOverflow,
  output logic [DROP_CNT_W-1:0] oDropCount
);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic pop_c;
  logic push_ok_c;
  logic drop_c;
  logic mem_we_c;

  // Status decoded from registered count
  assign oValid      = (count_q != '0);
  assign oFull       = (count_q == (AW+1)'(DEPTH));
  assign oAlmostFull = (count_q >= (AW+1)'(AFULL_LEVEL));
  assign oCount      = count_q;
  assign oOverflow   = overflow_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign pop_c     = oValid && iReady;
  assign push_ok_c = iFifoPush && (!oFull || pop_c);
  assign drop_c    = iFifoPush && oFull && !pop_c && !iFlush;
  assign mem_we_c  = push_ok_c && !iFlush;

  // Pointer / count / flag next state
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_c;
    if (iFlush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RGU_FIFO_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-push counter
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != DROP_CNT_W'(DROP_CNT_MAX))) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign oDropCount = drop_cnt_q;
`else
  assign oDropCount = '0;
`endif

  rgu_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (iClock),
    .we    (mem_we_c),
    .waddr (wr_ptr_q),
    .wdata (iFifoData),
    .raddr (rd_ptr_q),
    .rdata (oData)
  );

endmodule
